// File: rtl/posit_encode_raw_prodsumsum_es3_pkg.sv
// Shared ES3 posit definitions: widths, saturation scales, posit constants
// and the serialized raw product/sum value layout.
package posit_defines_es3;

  localparam int NBITS   = 32;
  localparam int ES      = 3;
  localparam int SCALE_W = 10;
  localparam int FRAC_W  = 62;

  // serialized raw value width: {sgn, scale, fraction, inf, zero}
  localparam int VALUE_PRODUCT_PROD_SUM_SUM_W = 1 + SCALE_W + FRAC_W + 2;

  // largest / smallest scale representable without saturating: (NBITS-2)*2^ES
  localparam logic signed [SCALE_W-1:0] MAXPOS_SCALE = 10'sd240;
  localparam logic signed [SCALE_W-1:0] MINPOS_SCALE = -10'sd240;

  localparam logic [NBITS-1:0] NAR    = 32'h8000_0000;
  localparam logic [NBITS-1:0] MAXPOS = 32'h7FFF_FFFF;
  localparam logic [NBITS-1:0] MINPOS = 32'h0000_0001;

  typedef struct packed {
    logic                      sgn;
    logic signed [SCALE_W-1:0] scale;
    logic [FRAC_W-1:0]         frac;   // 1.f, hidden bit excluded
    logic                      inf;
    logic                      zero;
  } value_product_prod_sum_sum;

endpackage

// File: rtl/posit_encode_raw_prodsumsum_es3_if.sv
// Raw-value-in / posit-word-out bus of the ES3 encoder.
interface posit_encode_raw_prodsumsum_es3_if;
  import posit_defines_es3::*;

  logic                                    start;
  logic [VALUE_PRODUCT_PROD_SUM_SUM_W-1:0] in1;
  logic                                    in1_truncated;
  logic [NBITS-1:0]                        result;
  logic                                    done;
  logic                                    truncated;
  logic                                    inexact;

  modport master (
    output start, in1, in1_truncated,
    input  result, done, truncated, inexact
  );

  modport slave (
    input  start, in1, in1_truncated,
    output result, done, truncated, inexact
  );
endinterface

// File: rtl/posit_encode_raw_prodsumsum_es3_regime_shift.sv
// Combinational regime/exponent/fraction packer. Produces the top NBITS-1
// magnitude bits plus guard and sticky for a given k, e and fraction.
module posit_regime_shift
  import posit_defines_es3::*;
(
  input  logic signed [SCALE_W-1:0] k,
  input  logic [ES-1:0]             e,
  input  logic [FRAC_W-1:0]         frac,
  output logic [NBITS-2:0]          kept,
  output logic                      guard,
  output logic                      sticky
);
  // NBITS of zero padding at the bottom absorb the largest in-range shift,
  // so nothing nonzero falls off the end before guard/sticky are taken.
  localparam int VW = 2 + ES + FRAC_W + NBITS;

  logic                 k_neg;
  logic [SCALE_W-1:0]   amt;
  logic signed [VW-1:0] base;
  logic signed [VW-1:0] shv;

  // Seed "10" (k>=0) or "01" (k<0) ahead of e/frac, then sign-extend right:
  // k>=0 replicates ones k times (k+1 ones, then 0); k<0 replicates zeros
  // -k-1 times (-k zeros, then 1). -k-1 is just ~k in two's complement.
  always_comb begin
    k_neg = k[SCALE_W-1];
    amt   = k_neg ? ~k : k;
    base  = {~k_neg, k_neg, e, frac, {NBITS{1'b0}}};
    shv   = base >>> amt;
  end

  assign kept   = shv[VW-1 -: NBITS-1];
  assign guard  = shv[VW-NBITS];
  assign sticky = |shv[VW-NBITS-1:0];

endmodule

// File: rtl/posit_encode_raw_prodsumsum_es3.sv
// 3-stage raw ES3 value -> 32-bit posit encoder with round-to-nearest-even,
// saturation to maxpos/minpos and NaR/zero special cases.
module posit_encode_raw_prodsumsum_es3
  import posit_defines_es3::*;
(
  input  logic                              clk,
  input  logic                              reset,
  posit_encode_raw_prodsumsum_es3_if.slave  bus
);
  localparam int STAGES = 3;

  logic [STAGES-1:0] vld_pipe;

  // S0 state
  value_product_prod_sum_sum s0_val;
  logic s0_nar, s0_zero, s0_trunc;

  // S1 combinational
  logic signed [SCALE_W-1:0] s1_k_c;
  logic [ES-1:0]             s1_e_c;
  logic [NBITS-2:0]          s1_kept_c;
  logic                      s1_guard_c, s1_sticky_c;
  logic                      s1_sat_hi_c, s1_sat_lo_c;

  // S1 state
  logic [NBITS-2:0] s1_kept;
  logic s1_guard, s1_sticky, s1_sat_hi, s1_sat_lo;
  logic s1_sgn, s1_nar, s1_zero, s1_trunc;

  // S2 combinational
  logic             rnd_up;
  logic [NBITS-2:0] mag;
  logic [NBITS-1:0] res_c;
  logic             inx_c;

  // S2 / output state
  logic [NBITS-1:0] res_q;
  logic             inx_q, trunc_q;

  // Stage valid shift register; "if (start)" treats an X start as idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
    end else begin
      if (bus.start) vld_pipe[0] <= 1'b1;
      else           vld_pipe[0] <= 1'b0;
      vld_pipe[STAGES-1:1] <= vld_pipe[STAGES-2:0];
    end
  end

  // S0: capture input and decode specials (inf beats zero).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s0_val   <= '0;
      s0_nar   <= 1'b0;
      s0_zero  <= 1'b0;
      s0_trunc <= 1'b0;
    end else if (bus.start) begin
      s0_val   <= value_product_prod_sum_sum'(bus.in1);
      s0_nar   <= bus.in1[1];
      s0_zero  <= bus.in1[0] & ~bus.in1[1];
      s0_trunc <= bus.in1_truncated;
    end
  end

  // S1: split scale into regime count and exponent, flag saturation.
  always_comb begin
    s1_k_c      = $signed(s0_val.scale) >>> ES;
    s1_e_c      = s0_val.scale[ES-1:0];
    s1_sat_hi_c = $signed(s0_val.scale) > MAXPOS_SCALE;
    s1_sat_lo_c = $signed(s0_val.scale) < MINPOS_SCALE;
  end

  posit_regime_shift u_shift (
    .k      (s1_k_c),
    .e      (s1_e_c),
    .frac   (s0_val.frac),
    .kept   (s1_kept_c),
    .guard  (s1_guard_c),
    .sticky (s1_sticky_c)
  );

  // S1 register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_kept   <= '0;
      s1_guard  <= 1'b0;
      s1_sticky <= 1'b0;
      s1_sat_hi <= 1'b0;
      s1_sat_lo <= 1'b0;
      s1_sgn    <= 1'b0;
      s1_nar    <= 1'b0;
      s1_zero   <= 1'b0;
      s1_trunc  <= 1'b0;
    end else if (vld_pipe[0]) begin
      s1_kept   <= s1_kept_c;
      s1_guard  <= s1_guard_c;
      s1_sticky <= s1_sticky_c;
      s1_sat_hi <= s1_sat_hi_c;
      s1_sat_lo <= s1_sat_lo_c;
      s1_sgn    <= s0_val.sgn;
      s1_nar    <= s0_nar;
      s1_zero   <= s0_zero;
      s1_trunc  <= s0_trunc;
    end
  end

  // S2: nearest-even round (never past maxpos), saturate, negate, specials.
  // A carry out of the fraction ripples into exponent/regime, which is still
  // the correctly rounded posit because the encoding is monotonic.
  always_comb begin
    rnd_up = s1_guard & (s1_sticky | s1_kept[0]) & ~(&s1_kept);
    mag    = s1_kept + {{(NBITS-2){1'b0}}, rnd_up};
    inx_c  = s1_guard | s1_sticky;
    if (s1_sat_hi) begin
      mag   = MAXPOS[NBITS-2:0];
      inx_c = 1'b1;
    end else if (s1_sat_lo) begin
      mag   = MINPOS[NBITS-2:0];
      inx_c = 1'b1;
    end
    res_c = s1_sgn ? (~{1'b0, mag} + {{(NBITS-1){1'b0}}, 1'b1}) : {1'b0, mag};
    if (s1_nar) begin
      res_c = NAR;
      inx_c = 1'b0;
    end else if (s1_zero) begin
      res_c = '0;
      inx_c = 1'b0;
    end
  end

  // Output registers hold their last value between done pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_q   <= '0;
      inx_q   <= 1'b0;
      trunc_q <= 1'b0;
    end else if (vld_pipe[1]) begin
      res_q   <= res_c;
      inx_q   <= inx_c;
      trunc_q <= s1_trunc;
    end
  end

  assign bus.result    = res_q;
  assign bus.inexact   = inx_q;
  assign bus.truncated = trunc_q;
  assign bus.done      = vld_pipe[STAGES-1];

endmodule

// File: tb/tb_posit_encode_raw_prodsumsum_es3.sv
// Bench for the ES3 raw->posit encoder: directed spec cases, bursts, reset
// flush, X start, then random values against a bit-string reference model.
module tb_posit_encode_raw_prodsumsum_es3;
  import posit_defines_es3::*;

  localparam int RW = VALUE_PRODUCT_PROD_SUM_SUM_W;

  logic clk;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  posit_encode_raw_prodsumsum_es3_if bus();

  posit_encode_raw_prodsumsum_es3 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] res;
    logic        inx;
    logic        trunc;
    int          launch;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [RW-1:0] mk(bit s, int sc, logic [61:0] f, bit inf, bit z);
    logic [9:0] s10;
    s10 = sc[9:0];
    return {s, s10, f, inf, z};
  endfunction

  // Reference: write the posit bit string out literally, then cut and round.
  task automatic model(input bit s, input int sc, input logic [61:0] f,
                       input bit inf, input bit z,
                       output logic [31:0] res, output logic inx);
    bit          bq[$];
    int          k, e;
    logic [30:0] m;
    bit          g, st, up;
    if (inf) begin res = 32'h8000_0000; inx = 0; return; end
    if (z)   begin res = 32'h0;         inx = 0; return; end
    if (sc > 240)       begin m = 31'h7FFF_FFFF; inx = 1; end
    else if (sc < -240) begin m = 31'h1;         inx = 1; end
    else begin
      k = (sc >= 0) ? sc / 8 : -((-sc + 7) / 8);
      e = sc - 8 * k;
      if (k >= 0) begin
        for (int i = 0; i <= k; i++) bq.push_back(1'b1);
        bq.push_back(1'b0);
      end else begin
        for (int i = 0; i < -k; i++) bq.push_back(1'b0);
        bq.push_back(1'b1);
      end
      for (int i = 2; i >= 0; i--) bq.push_back(e[i]);
      for (int i = 61; i >= 0; i--) bq.push_back(f[i]);
      m = 0;
      for (int i = 0; i < 31; i++) m = {m[29:0], bq[i]};
      g  = bq[31];
      st = 0;
      for (int i = 32; i < bq.size(); i++) st |= bq[i];
      up  = g && (st || m[0]) && (m != 31'h7FFF_FFFF);
      m   = m + 31'(up);
      inx = g | st;
    end
    res = {1'b0, m};
    if (s) res = 32'h0 - res;
  endtask

  task automatic drive(logic [RW-1:0] raw, logic tr);
    @(posedge clk); #1;
    bus.start         = 1'b1;
    bus.in1           = raw;
    bus.in1_truncated = tr;
  endtask

  task automatic send_exp(logic [RW-1:0] raw, logic tr, logic [31:0] res, logic inx);
    exp_t ex;
    drive(raw, tr);
    ex.res = res; ex.inx = inx; ex.trunc = tr; ex.launch = cyc;
    q.push_back(ex);
  endtask

  task automatic send_rnd();
    bit          s, inf, z, tr;
    int          sc;
    logic [61:0] f;
    logic [63:0] w;
    logic [31:0] r;
    logic        x;
    s   = 1'($urandom);
    sc  = int'($urandom_range(520)) - 260;
    w   = {$urandom, $urandom};
    f   = w[61:0];
    inf = ($urandom_range(15) == 0);
    z   = ($urandom_range(15) == 0);
    tr  = 1'($urandom);
    model(s, sc, f, inf, z, r, x);
    send_exp(mk(s, sc, f, inf, z), tr, r, x);
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
  endtask

  // Scoreboard: every done must match the oldest expectation, 3 cycles late.
  always @(negedge clk) begin
    if (!reset && bus.done) begin
      if (q.size() == 0) begin
        chk("spurious_done", bus.done, 0);
      end else begin
        exp_t ex;
        ex = q.pop_front();
        chk("result",    bus.result,    ex.res);
        chk("inexact",   bus.inexact,   ex.inx);
        chk("truncated", bus.truncated, ex.trunc);
        chk("latency",   cyc - ex.launch, 3);
      end
    end
  end

  initial begin
    logic [61:0] f_tie, f_up, f_ones;
    int n;
    clk = 0;
    reset = 1;
    bus.start = 0;
    bus.in1 = '0;
    bus.in1_truncated = 0;
    f_tie  = 62'(1) << 35;
    f_up   = f_tie | (62'(1) << 34);
    f_ones = '1;

    repeat (2) @(negedge clk);
    chk("rst_result", bus.result, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_trunc", bus.truncated, 0);
    chk("rst_inexact", bus.inexact, 0);
    @(posedge clk); #1 reset = 0;

    // directed cases, with bubbles between
    send_exp(mk(0,    0, 0, 0, 0), 0, 32'h4000_0000, 0); idle(1);
    send_exp(mk(0,    8, 0, 0, 0), 1, 32'h6000_0000, 0); idle(2);
    send_exp(mk(0,   -1, 0, 0, 0), 0, 32'h3C00_0000, 0);
    send_exp(mk(1,    0, 0, 0, 0), 0, 32'hC000_0000, 0); idle(1);
    send_exp(mk(0,    0, f_tie, 0, 0), 0, 32'h4000_0000, 1);
    send_exp(mk(0,    0, f_up,  0, 0), 0, 32'h4000_0001, 1);
    send_exp(mk(0,  300, 0, 0, 0), 0, 32'h7FFF_FFFF, 1);
    send_exp(mk(0, -300, 0, 0, 0), 0, 32'h0000_0001, 1);
    send_exp(mk(1,  300, 0, 0, 0), 0, 32'h8000_0001, 1);
    send_exp(mk(0,  240, 0, 0, 0), 0, 32'h7FFF_FFFF, 0);
    send_exp(mk(0,  240, f_ones, 0, 0), 0, 32'h7FFF_FFFF, 1);
    send_exp(mk(0, -240, 0, 0, 0), 0, 32'h0000_0001, 0);
    send_exp(mk(0,    5, 0, 1, 1), 0, 32'h8000_0000, 0);
    send_exp(mk(1,    5, f_ones, 0, 1), 1, 32'h0000_0000, 0);
    idle(4);

    // clean back-to-back burst, truncated pattern 1,0,1,1,0
    send_exp(mk(0,   0, 0, 0, 0), 1, 32'h4000_0000, 0);
    send_exp(mk(0,   8, 0, 0, 0), 0, 32'h6000_0000, 0);
    send_exp(mk(0,  -1, 0, 0, 0), 1, 32'h3C00_0000, 0);
    send_exp(mk(0,  16, 0, 0, 0), 1, 32'h7000_0000, 0);
    send_exp(mk(0,  -8, 0, 0, 0), 0, 32'h2000_0000, 0);
    idle(6);

    // same burst, reset asserted in its 3rd cycle: everything in flight drops
    drive(mk(0,  0, 0, 0, 0), 1);
    drive(mk(0,  8, 0, 0, 0), 0);
    drive(mk(0, -1, 0, 0, 0), 1);
    #2 reset = 1;
    q.delete();
    bus.start = 0;
    @(negedge clk);
    chk("flush_result", bus.result, 0);
    chk("flush_done", bus.done, 0);
    chk("flush_trunc", bus.truncated, 0);
    chk("flush_inexact", bus.inexact, 0);
    @(posedge clk); #1 reset = 0;
    repeat (8) begin
      @(negedge clk);
      chk("post_rst_done", bus.done, 0);
    end
    send_exp(mk(0, 8, 0, 0, 0), 1, 32'h6000_0000, 0);
    idle(6);

    // X on start for two cycles must not launch anything
    @(posedge clk); #1 bus.start = 1'bx;
    @(posedge clk); #1 bus.start = 1'bx;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("x_start_done", bus.done, 0);
    end

    // random traffic with occasional bubbles
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3) == 0) idle(1);
      send_rnd();
    end
    idle(1);

    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
